// File: rtl/decoder_3to8_if.sv
// Select/enable bus for the registered 3-to-8 decoder.
// The master drives E/A; the decoder (slave) returns the registered Y/y_valid.
interface decoder_3to8_if;
  logic       E;
  logic [2:0] A;
  logic [7:0] Y;
  logic       y_valid;

  modport master (output E, A, input Y, y_valid);
  modport slave  (input E, A, output Y, y_valid);
endinterface

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 line decoder with active-high enable.
// Y is one-hot (or one-cold when OUT_ACTIVE_LOW) one clock after E/A are sampled.
module decoder_3to8 #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  decoder_3to8_if.slave  bus
);

  localparam logic [7:0] YIdle = OUT_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [7:0] y_d, y_q;
  logic       valid_d, valid_q;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch is inferred.
    y_d     = 8'h00;
    valid_d = bus.E;
    if (bus.E) begin
      y_d[bus.A] = 1'b1;
    end
    if (OUT_ACTIVE_LOW) begin
      y_d = ~y_d;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so all state updates see pre-edge values.
    if (!rst_n) begin
      y_q     <= YIdle;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign bus.Y       = y_q;
  assign bus.y_valid = valid_q;

endmodule

// File: tb/tb_decoder_3to8.sv
// Directed bench for decoder_3to8: both polarities driven in lockstep,
// expectations queued at drive time and compared one edge later.
module tb_decoder_3to8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decoder_3to8_if bus_h ();
  decoder_3to8_if bus_l ();

  decoder_3to8 #(.OUT_ACTIVE_LOW(1'b0)) dut_h (.clk(clk), .rst_n(rst_n), .bus(bus_h));
  decoder_3to8 #(.OUT_ACTIVE_LOW(1'b1)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));

  typedef struct {
    string      tag;
    logic [7:0] y_hi;
    logic [7:0] y_lo;
    logic       v;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference mapping written directly from the decode table.
  function automatic logic [7:0] decode_ref(input logic e, input logic [2:0] a);
    case ({e, a})
      4'b1000: return 8'b00000001;
      4'b1001: return 8'b00000010;
      4'b1010: return 8'b00000100;
      4'b1011: return 8'b00001000;
      4'b1100: return 8'b00010000;
      4'b1101: return 8'b00100000;
      4'b1110: return 8'b01000000;
      4'b1111: return 8'b10000000;
      default: return 8'b00000000;
    endcase
  endfunction

  // Drive one cycle of stimulus, queue its expectation, then check after the edge.
  task automatic step(input string tag, input logic rst, input logic e, input logic [2:0] a);
    exp_t x;
    rst_n   = rst;
    bus_h.E = e;  bus_h.A = a;
    bus_l.E = e;  bus_l.A = a;
    x.tag  = tag;
    x.y_hi = rst ? decode_ref(e, a) : 8'h00;
    x.y_lo = rst ? ~decode_ref(e, a) : 8'hFF;
    x.v    = rst ? e : 1'b0;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check({x.tag, "/Y"},       bus_h.Y, x.y_hi);
    check({x.tag, "/Y_low"},   bus_l.Y, x.y_lo);
    check({x.tag, "/valid"},   {7'd0, bus_h.y_valid}, {7'd0, x.v});
    check({x.tag, "/valid_l"}, {7'd0, bus_l.y_valid}, {7'd0, x.v});
    check({x.tag, "/onehot0"}, {7'd0, $onehot0(bus_h.Y)}, 8'd1);
    if (x.v) begin
      check({x.tag, "/onehot"},  {7'd0, $onehot(bus_h.Y)}, 8'd1);
      check({x.tag, "/onecold"}, {7'd0, $onehot(~bus_l.Y)}, 8'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_h.E = 1'b0; bus_h.A = 3'd0;
    bus_l.E = 1'b0; bus_l.A = 3'd0;
    #1;

    step("reset0", 1'b0, 1'b1, 3'b101);
    step("reset1", 1'b0, 1'b1, 3'b101);
    step("release", 1'b1, 1'b1, 3'b101);

    step("disabled0", 1'b1, 1'b0, 3'b000);
    step("disabled1", 1'b1, 1'b0, 3'b000);

    step("sweep000", 1'b1, 1'b1, 3'b000);
    step("sweep001", 1'b1, 1'b1, 3'b001);
    step("sweep010", 1'b1, 1'b1, 3'b010);
    step("sweep011", 1'b1, 1'b1, 3'b011);
    step("sweep111", 1'b1, 1'b1, 3'b111);

    for (int i = 0; i < 16; i++) begin
      logic [3:0] ea;
      ea = 4'(i);
      step($sformatf("exh_E%0d_A%0d", ea[3], ea[2:0]), 1'b1, ea[3], ea[2:0]);
    end

    for (int i = 0; i < 6; i++) begin
      step($sformatf("b2b%0d", i), 1'b1, 1'b1, (i % 2 == 0) ? 3'b000 : 3'b111);
    end

    step("edrop_on",  1'b1, 1'b1, 3'b011);
    step("edrop_off", 1'b1, 1'b0, 3'b011);

    step("al_010",    1'b1, 1'b1, 3'b010);
    step("mid_rst",   1'b0, 1'b1, 3'b110);
    step("mid_resume", 1'b1, 1'b1, 3'b110);
    step("mid_move",  1'b1, 1'b1, 3'b100);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_3to8.md
Name: decoder_3to8

Overview:
- Registered 3-to-8 line decoder with active-high enable.
- Converts a 3-bit binary select A into a one-hot 8-bit output Y, gated by enable E.
- Used in the CPU datapath for register-file write-select and unit-select decoding.
- Output is registered: one clock of latency, glitch-free one-hot downstream.

Parameters:
- OUT_ACTIVE_LOW, 0, when 1 the registered Y is bitwise inverted (asserted line = 0, idle = all ones); default is active-high one-hot.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- E  input  1  decode enable, active high.
- A  input  3  binary select, A[2] MSB.
- Y  output  8  registered decoded output; bit index equals selected value of A.
- y_valid  output  1  registered copy of E; high when Y carries a decoded line.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset:
  - On rising clk with rst_n=0: Y <= 8'b00000000 (8'b11111111 if OUT_ACTIVE_LOW=1) and y_valid <= 0.
  - Reset has priority over E and A.
- Decode, combinational next-state:
  - E=1: next_Y = 8'b1 << A, i.e. exactly bit A set, all other bits clear.
  - E=0: next_Y = 8'b00000000 regardless of A.
  - OUT_ACTIVE_LOW=1 inverts next_Y before registering.
- Latency:
  - Y and y_valid update on the rising clk edge after E/A are sampled (1 cycle).
  - No combinational path from E or A to Y.
- Mapping, E=1:
  - A=000 -> 00000001
  - A=001 -> 00000010
  - A=010 -> 00000100
  - A=011 -> 00001000
  - A=100 -> 00010000
  - A=101 -> 00100000
  - A=110 -> 01000000
  - A=111 -> 10000000
- Invariant: with E registered high, Y has exactly one asserted bit. With E registered low, no bit is asserted.
- A change of A while E=1 moves the asserted bit on the next edge. No intermediate cycle with zero or two bits asserted.
- Deassertion: E 1->0 clears Y and y_valid on the next edge.
- Reset mid-operation: rst_n low for one edge clears outputs. Decoding resumes on the first edge with rst_n=1, using the E/A present at that edge.
- X handling: any X/Z on E or A while rst_n=1 may propagate to Y. There is no requirement to sanitize.
- No handshake; E is a level, not a pulse.

Test Plan:
- Reset: rst_n=0 for 2 edges with E=1, A=101 -> Y=00000000, y_valid=0. First edge after release -> Y=00100000, y_valid=1.
- Disabled: E=0, A=000 for 20 ns -> Y=00000000 after next edge, y_valid=0.
- Enabled sweep: E=1, A stepped 000, 001, 010, 011, 111, each held ≥1 cycle -> Y = 00000001, 00000010, 00000100, 00001000, 10000000 respectively, each one cycle after the A change.
- Full exhaustive: all 16 combinations of {E, A} -> Y matches mapping or zero. Onehot0 check on Y every cycle; onehot check whenever y_valid=1.
- Back-to-back: A changes every cycle 000->111->000 with E=1 -> Y alternates 00000001 / 10000000 with no zero or multi-hot cycle.
- Enable drop and active-low variant: E falls while A=011 -> Y=00000000 next edge. With OUT_ACTIVE_LOW=1, A=010, E=1 -> Y=11111011, and reset value is 11111111.
